// File: rtl/szg_dac_seq_pkg.sv
// rtl/szg_dac_seq_pkg.sv - shared types and init table for the SYZYGY DAC SPI sequencer
package szg_dac_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT_ISSUE,
        S_INIT_WLOW,
        S_INIT_WHIGH,
        S_VFY_ISSUE,
        S_VFY_WLOW,
        S_VFY_WHIGH,
        S_HOST_ISSUE,
        S_HOST_WLOW,
        S_HOST_WHIGH,
        S_FINISH
    } state_t;

    typedef struct packed {
        logic [5:0] reg_addr;
        logic [7:0] data;
    } init_entry_t;

    localparam int NUM_INIT = 4;
    localparam int IDX_W    = (NUM_INIT > 1) ? $clog2(NUM_INIT) : 1;

    // Cycles the controller may take to drop spi_done after a send.
    localparam int WLOW_CYC = 4;

    localparam init_entry_t INIT_TABLE [NUM_INIT] = '{
        '{reg_addr: 6'h00, data: 8'h00},
        '{reg_addr: 6'h02, data: 8'h34},
        '{reg_addr: 6'h03, data: 8'h00},
        '{reg_addr: 6'h07, data: 8'h00}
    };

endpackage

// File: rtl/szg_dac_spi_sequencer_if.sv
// rtl/szg_dac_spi_sequencer_if.sv - control port between sequencer and DAC SPI controller
interface szg_dac_spi_sequencer_if;

    logic [5:0] spi_reg;
    logic [7:0] spi_data_in;
    logic       spi_rw;
    logic       spi_send;
    logic       spi_done;
    logic [7:0] spi_data_out;

    modport master (
        output spi_reg, spi_data_in, spi_rw, spi_send,
        input  spi_done, spi_data_out
    );

    modport slave (
        input  spi_reg, spi_data_in, spi_rw, spi_send,
        output spi_done, spi_data_out
    );

endinterface

// File: rtl/szg_dac_seq_timeout.sv
// rtl/szg_dac_seq_timeout.sv - loadable down-counter that flags expiry at zero
module szg_dac_seq_timeout #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt;

    // Reload on request, otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/szg_dac_spi_sequencer.sv
// rtl/szg_dac_spi_sequencer.sv - replays the DAC init table and arbitrates host register access
module szg_dac_spi_sequencer
    import szg_dac_seq_pkg::*;
#(
    parameter bit AUTO_INIT   = 1'b1,
    parameter bit VERIFY      = 1'b1,
    parameter int TIMEOUT_CYC = 8192
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_init,
    input  logic       host_req,
    input  logic       host_rw,
    input  logic [5:0] host_reg,
    input  logic [7:0] host_wdata,
    output logic       host_ack,
    output logic [7:0] host_rdata,
    output logic       host_err,
    output logic       busy,
    output logic       init_done,
    output logic       init_err,
    output logic [5:0] err_reg,
    szg_dac_spi_sequencer_if.master spi
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_t            state, next_state;
    logic [IDX_W-1:0]  idx;
    logic              auto_pend;
    logic              h_rw;
    logic [5:0]        h_reg;
    logic [7:0]        h_wdata;
    logic              tmo_load;
    logic [TW-1:0]     tmo_val;
    logic              tmo_exp;
    logic              go_init;
    logic              last_entry;
    logic              vfy_bad;
    logic              is_issue;
    logic              is_wlow;

    assign go_init    = start_init || auto_pend;
    assign last_entry = (idx == IDX_W'(NUM_INIT - 1));
    assign vfy_bad    = (spi.spi_data_out != INIT_TABLE[idx].data);

    szg_dac_seq_timeout #(.W(TW)) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .load     (tmo_load),
        .load_val (tmo_val),
        .expired  (tmo_exp)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Next-state: issue waits for an idle controller, each wait can time out into FINISH.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (go_init)       next_state = S_INIT_ISSUE;
                else if (host_req) next_state = S_HOST_ISSUE;
            end
            S_INIT_ISSUE: if (spi.spi_done) next_state = S_INIT_WLOW;
            S_VFY_ISSUE:  if (spi.spi_done) next_state = S_VFY_WLOW;
            S_HOST_ISSUE: if (spi.spi_done) next_state = S_HOST_WLOW;
            S_INIT_WLOW: begin
                if (!spi.spi_done) next_state = S_INIT_WHIGH;
                else if (tmo_exp)  next_state = S_FINISH;
            end
            S_VFY_WLOW: begin
                if (!spi.spi_done) next_state = S_VFY_WHIGH;
                else if (tmo_exp)  next_state = S_FINISH;
            end
            S_HOST_WLOW: begin
                if (!spi.spi_done) next_state = S_HOST_WHIGH;
                else if (tmo_exp)  next_state = S_FINISH;
            end
            S_INIT_WHIGH: begin
                if (spi.spi_done) begin
                    if (VERIFY)          next_state = S_VFY_ISSUE;
                    else if (last_entry) next_state = S_FINISH;
                    else                 next_state = S_INIT_ISSUE;
                end else if (tmo_exp) begin
                    next_state = S_FINISH;
                end
            end
            S_VFY_WHIGH: begin
                if (spi.spi_done) begin
                    if (vfy_bad || last_entry) next_state = S_FINISH;
                    else                       next_state = S_INIT_ISSUE;
                end else if (tmo_exp) begin
                    next_state = S_FINISH;
                end
            end
            S_HOST_WHIGH: if (spi.spi_done || tmo_exp) next_state = S_FINISH;
            S_FINISH:     next_state = S_IDLE;
            default:      next_state = S_IDLE;
        endcase
    end

    // Outputs: SPI command fields per transfer kind, send strobe and timeout reloads.
    always_comb begin
        spi.spi_reg     = 6'h00;
        spi.spi_data_in = 8'h00;
        spi.spi_rw      = 1'b0;
        is_issue        = 1'b0;
        is_wlow         = 1'b0;
        busy            = (state != S_IDLE);
        case (state)
            S_INIT_ISSUE, S_INIT_WLOW, S_INIT_WHIGH: begin
                spi.spi_reg     = INIT_TABLE[idx].reg_addr;
                spi.spi_data_in = INIT_TABLE[idx].data;
                spi.spi_rw      = 1'b1;
            end
            S_VFY_ISSUE, S_VFY_WLOW, S_VFY_WHIGH: begin
                spi.spi_reg = INIT_TABLE[idx].reg_addr;
            end
            S_HOST_ISSUE, S_HOST_WLOW, S_HOST_WHIGH: begin
                spi.spi_reg     = h_reg;
                spi.spi_data_in = h_wdata;
                spi.spi_rw      = h_rw;
            end
            default: ;
        endcase
        case (state)
            S_INIT_ISSUE, S_VFY_ISSUE, S_HOST_ISSUE: is_issue = 1'b1;
            S_INIT_WLOW, S_VFY_WLOW, S_HOST_WLOW:    is_wlow  = 1'b1;
            default: ;
        endcase
        spi.spi_send = is_issue && spi.spi_done;
        tmo_load     = spi.spi_send || (is_wlow && !spi.spi_done);
        tmo_val      = spi.spi_send ? TW'(WLOW_CYC) : TW'(TIMEOUT_CYC);
    end

    // Datapath: table index, sticky init status, host latches and host completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx        <= '0;
            auto_pend  <= AUTO_INIT;
            init_done  <= 1'b0;
            init_err   <= 1'b0;
            err_reg    <= 6'h00;
            h_rw       <= 1'b0;
            h_reg      <= 6'h00;
            h_wdata    <= 8'h00;
            host_ack   <= 1'b0;
            host_rdata <= 8'h00;
            host_err   <= 1'b0;
        end else begin
            host_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go_init) begin
                        idx       <= '0;
                        auto_pend <= 1'b0;
                        init_done <= 1'b0;
                        init_err  <= 1'b0;
                        err_reg   <= 6'h00;
                    end else if (host_req) begin
                        h_rw    <= host_rw;
                        h_reg   <= host_reg;
                        h_wdata <= host_wdata;
                    end
                end
                S_INIT_WLOW, S_VFY_WLOW: begin
                    if (spi.spi_done && tmo_exp) begin
                        init_err <= 1'b1;
                        err_reg  <= INIT_TABLE[idx].reg_addr;
                    end
                end
                S_INIT_WHIGH: begin
                    if (spi.spi_done) begin
                        if (!VERIFY) begin
                            if (last_entry) init_done <= 1'b1;
                            else            idx <= idx + IDX_W'(1);
                        end
                    end else if (tmo_exp) begin
                        init_err <= 1'b1;
                        err_reg  <= INIT_TABLE[idx].reg_addr;
                    end
                end
                S_VFY_WHIGH: begin
                    if (spi.spi_done) begin
                        if (vfy_bad) begin
                            init_err <= 1'b1;
                            err_reg  <= INIT_TABLE[idx].reg_addr;
                        end else if (last_entry) begin
                            init_done <= 1'b1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else if (tmo_exp) begin
                        init_err <= 1'b1;
                        err_reg  <= INIT_TABLE[idx].reg_addr;
                    end
                end
                S_HOST_WLOW: begin
                    if (spi.spi_done && tmo_exp) begin
                        host_ack   <= 1'b1;
                        host_err   <= 1'b1;
                        host_rdata <= 8'h00;
                    end
                end
                S_HOST_WHIGH: begin
                    if (spi.spi_done) begin
                        host_ack   <= 1'b1;
                        host_err   <= 1'b0;
                        host_rdata <= spi.spi_data_out;
                    end else if (tmo_exp) begin
                        host_ack   <= 1'b1;
                        host_err   <= 1'b1;
                        host_rdata <= 8'h00;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_szg_dac_spi_sequencer.sv
// tb/tb_szg_dac_spi_sequencer.sv - scoreboard bench with behavioural SPI controller model
module tb_szg_dac_spi_sequencer;

    typedef struct packed {
        logic       rw;
        logic [5:0] r;
        logic [7:0] d;
    } xfer_t;

    typedef struct packed {
        logic [7:0] rd;
        logic       e;
    } ack_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_init = 1'b0;
    logic       host_req = 1'b0;
    logic       host_rw = 1'b0;
    logic [5:0] host_reg = 6'h00;
    logic [7:0] host_wdata = 8'h00;
    logic       host_ack;
    logic [7:0] host_rdata;
    logic       host_err;
    logic       busy;
    logic       init_done;
    logic       init_err;
    logic [5:0] err_reg;

    szg_dac_spi_sequencer_if spi ();

    szg_dac_spi_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start_init (start_init),
        .host_req   (host_req),
        .host_rw    (host_rw),
        .host_reg   (host_reg),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .host_rdata (host_rdata),
        .host_err   (host_err),
        .busy       (busy),
        .init_done  (init_done),
        .init_err   (init_err),
        .err_reg    (err_reg),
        .spi        (spi)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [5:0] t_reg [4] = '{6'h00, 6'h02, 6'h03, 6'h07};
    logic [7:0] t_dat [4] = '{8'h00, 8'h34, 8'h00, 8'h00};

    xfer_t exp_q [$];
    xfer_t obs_q [$];
    ack_t  exp_ack [$];
    ack_t  obs_ack [$];

    // SPI controller model
    int         spi_lat = 3;
    bit         stuck = 1'b0;
    bit         corrupt = 1'b0;
    logic [7:0] mem [64];
    int         m_cnt;
    logic       m_rw;
    logic [5:0] m_reg;
    logic [7:0] m_din;

    initial for (int i = 0; i < 64; i++) mem[i] = 8'h00;

    always @(posedge clk) begin
        if (reset) begin
            spi.spi_done     <= 1'b1;
            spi.spi_data_out <= 8'h00;
            m_cnt            <= 0;
        end else if (spi.spi_done) begin
            if (spi.spi_send && !stuck) begin
                spi.spi_done <= 1'b0;
                m_cnt        <= spi_lat;
                m_rw         <= spi.spi_rw;
                m_reg        <= spi.spi_reg;
                m_din        <= spi.spi_data_in;
            end
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
        end else begin
            spi.spi_done <= 1'b1;
            if (m_rw) begin
                mem[m_reg]       <= m_din;
                spi.spi_data_out <= 8'h00;
            end else begin
                spi.spi_data_out <= mem[m_reg] ^ ((corrupt && m_reg == 6'h02) ? 8'h01 : 8'h00);
            end
        end
    end

    // Monitor: record every send strobe and host acknowledge
    always @(negedge clk) begin
        if (!reset) begin
            if (spi.spi_send) obs_q.push_back('{spi.spi_rw, spi.spi_reg, spi.spi_data_in});
            if (host_ack) obs_ack.push_back('{host_rdata, host_err});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push_init(input int last_entry);
        for (int i = 0; i <= last_entry; i++) begin
            exp_q.push_back('{1'b1, t_reg[i], t_dat[i]});
            exp_q.push_back('{1'b0, t_reg[i], 8'h00});
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_init = 1'b1;
        @(negedge clk);
        start_init = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok, output int lat);
        ok = 1'b0;
        lat = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            lat++;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic host_access(input logic rw, input logic [5:0] r, input logic [7:0] d,
                               output bit ok, output int lat);
        @(negedge clk);
        host_req = 1'b1;
        host_rw = rw;
        host_reg = r;
        host_wdata = d;
        ok = 1'b0;
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            lat++;
            if (host_ack) begin
                ok = 1'b1;
                break;
            end
        end
        host_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [34:0] v;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        v = {host_ack, host_rdata, host_err, busy, init_done, init_err, err_reg,
             spi.spi_reg, spi.spi_data_in, spi.spi_rw, spi.spi_send};
        checks++;
        if (v !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", v);
        end
    endtask

    task automatic test_auto_init();
        bit ok;
        int lat;
        xfer_t e, o;
        push_init(3);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, spi.spi_send} !== 2'b11) begin
            errors++;
            $display("FAIL auto_first_cycle: busy/send got %b want 11", {busy, spi.spi_send});
        end
        wait_idle(500, ok, lat);
        checks++;
        if (!ok) begin errors++; $display("FAIL auto_idle: busy never dropped"); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL auto_count: got %0d sends want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL auto_send: got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        checks++;
        if ({init_done, init_err, busy} !== 3'b100) begin
            errors++;
            $display("FAIL auto_flags: done/err/busy got %b want 100", {init_done, init_err, busy});
        end
    endtask

    task automatic test_verify_mismatch();
        bit ok;
        int lat;
        xfer_t e, o;
        corrupt = 1'b1;
        push_init(1);
        pulse_start();
        wait_idle(500, ok, lat);
        corrupt = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL vfy_idle: busy never dropped"); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL vfy_count: got %0d sends want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL vfy_send: got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        checks++;
        if ({init_done, init_err, err_reg} !== {1'b0, 1'b1, 6'h02}) begin
            errors++;
            $display("FAIL vfy_flags: done/err/reg got %b/%b/%h want 0/1/02", init_done, init_err, err_reg);
        end
    endtask

    task automatic test_host_access();
        bit ok;
        int lat;
        xfer_t e, o;
        ack_t ea, oa;
        exp_q.push_back('{1'b1, 6'h07, 8'hA5});
        exp_ack.push_back('{8'h00, 1'b0});
        host_access(1'b1, 6'h07, 8'hA5, ok, lat);
        checks++;
        if (!ok) begin errors++; $display("FAIL host_wr_ack: no host_ack"); end
        exp_q.push_back('{1'b0, 6'h07, 8'h00});
        exp_ack.push_back('{8'hA5, 1'b0});
        host_access(1'b0, 6'h07, 8'h00, ok, lat);
        checks++;
        if (!ok || lat != 7) begin
            errors++;
            $display("FAIL host_rd_latency: got %0d cycles (ack=%0b) want 7", lat, ok);
        end
        checks++;
        if (obs_q.size() != exp_q.size() || obs_ack.size() != exp_ack.size()) begin
            errors++;
            $display("FAIL host_count: sends %0d acks %0d want %0d %0d",
                     obs_q.size(), obs_ack.size(), exp_q.size(), exp_ack.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL host_send: got %h want %h", o, e); end
        end
        while (exp_ack.size() > 0 && obs_ack.size() > 0) begin
            ea = exp_ack.pop_front();
            oa = obs_ack.pop_front();
            checks++;
            if (oa !== ea) begin errors++; $display("FAIL host_ack_data: got %h want %h", oa, ea); end
        end
        exp_q.delete(); obs_q.delete(); exp_ack.delete(); obs_ack.delete();
    endtask

    task automatic test_priority();
        bit got_ack;
        xfer_t e, o;
        ack_t ea, oa;
        push_init(3);
        exp_q.push_back('{1'b0, 6'h02, 8'h00});
        exp_ack.push_back('{8'h34, 1'b0});
        @(negedge clk);
        start_init = 1'b1;
        host_req = 1'b1;
        host_rw = 1'b0;
        host_reg = 6'h02;
        host_wdata = 8'h00;
        @(negedge clk);
        start_init = 1'b0;
        got_ack = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (host_ack) begin
                got_ack = 1'b1;
                break;
            end
            @(negedge clk);
        end
        host_req = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (!got_ack) begin errors++; $display("FAIL prio_ack: no host_ack"); end
        checks++;
        if (obs_q.size() != exp_q.size() || obs_ack.size() != exp_ack.size()) begin
            errors++;
            $display("FAIL prio_count: sends %0d acks %0d want %0d %0d",
                     obs_q.size(), obs_ack.size(), exp_q.size(), exp_ack.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL prio_send: got %h want %h", o, e); end
        end
        while (exp_ack.size() > 0 && obs_ack.size() > 0) begin
            ea = exp_ack.pop_front();
            oa = obs_ack.pop_front();
            checks++;
            if (oa !== ea) begin errors++; $display("FAIL prio_ack_data: got %h want %h", oa, ea); end
        end
        exp_q.delete(); obs_q.delete(); exp_ack.delete(); obs_ack.delete();
        checks++;
        if ({init_done, init_err, busy} !== 3'b100) begin
            errors++;
            $display("FAIL prio_flags: done/err/busy got %b want 100", {init_done, init_err, busy});
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int lat;
        xfer_t e, o;
        stuck = 1'b1;
        exp_q.push_back('{1'b1, 6'h00, 8'h00});
        pulse_start();
        wait_idle(50, ok, lat);
        stuck = 1'b0;
        checks++;
        if (!ok || lat != 7) begin
            errors++;
            $display("FAIL tmo_latency: got %0d cycles (idle=%0b) want 7", lat, ok);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL tmo_count: got %0d sends want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL tmo_send: got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        checks++;
        if ({init_done, init_err, err_reg} !== {1'b0, 1'b1, 6'h00}) begin
            errors++;
            $display("FAIL tmo_flags: done/err/reg got %b/%b/%h want 0/1/00", init_done, init_err, err_reg);
        end
    endtask

    task automatic test_reset_mid_transfer();
        bit ok, found;
        int lat;
        logic [34:0] v;
        xfer_t e, o;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        obs_q.delete();
        reset = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (obs_q.size() >= 5) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL rst_reach_entry2: W03 not seen"); end
        @(negedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        v = {host_ack, host_rdata, host_err, busy, init_done, init_err, err_reg,
             spi.spi_reg, spi.spi_data_in, spi.spi_rw, spi.spi_send};
        checks++;
        if (v !== 35'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %h want 0", v);
        end
        @(negedge clk);
        obs_q.delete();
        push_init(3);
        reset = 1'b0;
        @(negedge clk);
        wait_idle(500, ok, lat);
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_idle: busy never dropped"); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rst_count: got %0d sends want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL rst_send: got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        checks++;
        if ({init_done, init_err, err_reg} !== {1'b1, 1'b0, 6'h00}) begin
            errors++;
            $display("FAIL rst_flags: done/err/reg got %b/%b/%h want 1/0/00", init_done, init_err, err_reg);
        end
    endtask

    initial begin
        test_reset();
        test_auto_init();
        test_verify_mismatch();
        test_host_access();
        test_priority();
        test_timeout();
        test_reset_mid_transfer();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
